reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order retirement buffer between dispatch (allocator) and the register file, downstream of both execute pipelines.
- Allocates one entry per dispatched instruction and hands back its ROB tag.
- Captures results from two CDB ports, serves operand lookups to dispatch, and retires at most one completed instruction per cycle in program order.
- Tags are 1-based (tag = index + 1); tag 0 means "no producer".

Parameters:
- ROB_SIZE, 16, number of entries.
- TAG_WIDTH, 5, tag width; must hold the values 0..ROB_SIZE.
- DATA_WIDTH, 64, result width.
- REG_WIDTH, 5, architectural register index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all entries (mispredict recovery).
- alloc_valid  in  1  dispatch requests an entry this cycle.
- alloc_has_rd  in  1  instruction writes a destination register.
- alloc_rd  in  REG_WIDTH  destination register.
- alloc_pc  in  64  instruction PC.
- alloc_ready  out  1  entry available (count < ROB_SIZE).
- alloc_tag  out  TAG_WIDTH  tag granted if allocation occurs this cycle (tail + 1).
- cdb1_valid / cdb2_valid  in  1  result broadcast valid, one per execute pipeline.
- cdb1_tag / cdb2_tag  in  TAG_WIDTH  producing tag.
- cdb1_value / cdb2_value  in  DATA_WIDTH  result value.
- src1_tag / src2_tag  in  TAG_WIDTH  operand producer tags to look up.
- src1_ready / src2_ready  out  1  producer value available.
- src1_value / src2_value  out  DATA_WIDTH  producer value, valid when ready.
- commit_valid  out  1  head entry retires this cycle.
- commit_tag  out  TAG_WIDTH  retiring tag.
- commit_has_rd  out  1  retiring instruction writes a register.
- commit_rd  out  REG_WIDTH  retiring destination register.
- commit_value  out  DATA_WIDTH  retiring result.
- commit_pc  out  64  retiring PC.
- count  out  TAG_WIDTH  occupied entries.

Behaviour:
- State:
  - Entry array; each entry holds valid, done, has_rd, rd, pc, value.
  - head and tail indices in 0..ROB_SIZE-1.
  - count in 0..ROB_SIZE.
- Reset (async) and flush (sync, highest priority over all other events in that cycle):
  - all valid/done cleared; head = tail = count = 0.
  - Outputs after reset: alloc_ready=1, alloc_tag=1, commit_valid=0, count=0.
  - Combinational outputs carry no entry data while the buffer is empty.
  - Reset mid-operation discards all in-flight entries.
- Allocation:
  - Occurs when alloc_valid && alloc_ready.
  - Entry[tail] is written with valid=1, done=0, has_rd, rd, pc, and value=0.
  - tail advances by one; wraps ROB_SIZE-1 to 0.
  - alloc_ready depends only on registered count; no same-cycle commit bypass. A full ROB refuses allocation even if commit fires that cycle.
  - alloc_valid while full is ignored; no state change.
- Writeback:
  - For each CDB port with valid=1: if entry[tag-1] is valid and not done, set done=1 and write value.
  - Tag 0, tags > ROB_SIZE, invalid entries and already-done entries are ignored.
  - Both ports carrying the same tag: cdb1 wins.
- Commit (combinational from head, one per cycle):
  - commit_valid = entry[head].valid && entry[head].done && !flush.
  - The other commit_* outputs reflect entry[head]; commit_tag = head + 1.
  - On posedge with commit_valid=1: entry[head].valid cleared and head advances with wrap.
  - The register file never stalls commit.
- Count:
  - +1 on allocation, -1 on commit, unchanged when both occur.
  - Never exceeds ROB_SIZE and never underflows.
- Operand lookup (combinational, per source):
  - tag 0: ready=1, value=0.
  - Else if cdb1 matches the tag this cycle, forward cdb1_value with ready=1; else if cdb2 matches, forward cdb2_value with ready=1.
  - Else if entry[tag-1] is valid && done, return its value with ready=1.
  - Otherwise ready=0, value=0.
- A CDB broadcast for the tag being allocated in the same cycle cannot occur and needs no handling.

Decomposition:
- Shared consts/types file:
  - ROB_SIZE, ROB tag width, and the rob_entry struct (valid, done, has_rd, rd, pc, value).
  - One cdb_packet struct (valid, tag, value), reused by reservation stations.
- One sub-module, rob_pointer: wrap-around index register with increment enable, sync clear, async reset. Instantiated twice, for head and tail.

Test Plan:
- Reset then idle:
  - Assert reset 3 cycles -> count=0, alloc_ready=1, alloc_tag=1, commit_valid=0.
- Out-of-order completion, in-order retire:
  - Allocate PCs 0x100/0x104/0x108 (rd=1,2,3) -> tags 1,2,3.
  - cdb1 tag3=0x33, then cdb2 tag1=0x11, then cdb1 tag2=0x22.
  - Required: commits tag1 (rd1, 0x11), then tag2, then tag3 on consecutive cycles; count returns to 0.
- Full and wrap:
  - Allocate 16 with no writeback -> alloc_ready=0, count=16; a 17th alloc_valid leaves count at 16.
  - Complete tag1 and commit it, then allocate -> granted tag 1 (wrap); head points to tag 2.
- Same-cycle events:
  - cdb1 and cdb2 both tag 4, values 0xAA and 0xBB -> entry stores 0xAA.
  - src1_tag=4 that cycle -> ready=1, value 0xAA.
  - Simultaneous alloc and commit -> count unchanged.
- Lookup:
  - src2_tag=0 -> ready=1, value 0.
  - src2_tag of an allocated, not-done entry -> ready=0.
- Flush mid-operation:
  - 5 entries live, 2 of them done, assert flush -> next cycle count=0 and alloc_tag=1.
  - No commit_valid during the flush cycle; a CDB broadcast in the flush cycle is dropped.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer and its neighbours.
//   ROB_ENTRIES / ROB_TAG_W / ROB_DATA_W / ROB_REG_W / ROB_PC_W : geometry
//   rob_entry_t    : one buffer slot (valid, done, has_rd, rd, pc, value)
//   cdb_packet_t   : one common-data-bus broadcast (valid, tag, value),
//                    also consumed by the reservation stations
//   rob_idx_to_tag : slot index -> 1-based tag
package reorder_buffer_pkg;

    localparam int ROB_ENTRIES = 16;
    localparam int ROB_TAG_W   = 5;
    localparam int ROB_DATA_W  = 64;
    localparam int ROB_REG_W   = 5;
    localparam int ROB_PC_W    = 64;
    localparam int ROB_IDX_W   = $clog2(ROB_ENTRIES);

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  has_rd;
        logic [ROB_REG_W-1:0]  rd;
        logic [ROB_PC_W-1:0]   pc;
        logic [ROB_DATA_W-1:0] value;
    } rob_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [ROB_TAG_W-1:0]  tag;
        logic [ROB_DATA_W-1:0] value;
    } cdb_packet_t;

    // Tag 0 is reserved for "no producer", so slot i carries tag i+1.
    function automatic logic [ROB_TAG_W-1:0] rob_idx_to_tag(input logic [ROB_IDX_W-1:0] idx);
        return ROB_TAG_W'(idx) + ROB_TAG_W'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer_rob_pointer.sv
// Wrap-around index register used for the head and tail of the buffer.
//   clk, reset : clock, asynchronous active-high reset
//   i_clr      : synchronous clear to 0 (wins over i_inc)
//   i_inc      : advance by one, wrapping DEPTH-1 -> 0
//   o_ptr      : current index
module rob_pointer #(
    parameter int DEPTH = 16,
    parameter int W     = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);

    logic [W-1:0] r_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= (r_ptr == W'(DEPTH - 1)) ? '0 : r_ptr + W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer between dispatch and the register file.
//   alloc_*  : dispatch allocates one entry per cycle, granted tag = tail+1
//   cdb1/2_* : two result broadcasts; cdb1 wins when both carry the same tag
//   src1/2_* : combinational operand lookup with same-cycle CDB forwarding
//   commit_* : combinational view of the head, retires when it is done
//   count    : occupied entries
//   flush    : synchronous clear, overrides every other event that cycle
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE   = reorder_buffer_pkg::ROB_ENTRIES,
    parameter int TAG_WIDTH  = reorder_buffer_pkg::ROB_TAG_W,
    parameter int DATA_WIDTH = reorder_buffer_pkg::ROB_DATA_W,
    parameter int REG_WIDTH  = reorder_buffer_pkg::ROB_REG_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  alloc_valid,
    input  logic                  alloc_has_rd,
    input  logic [REG_WIDTH-1:0]  alloc_rd,
    input  logic [63:0]           alloc_pc,
    output logic                  alloc_ready,
    output logic [TAG_WIDTH-1:0]  alloc_tag,
    input  logic                  cdb1_valid,
    input  logic [TAG_WIDTH-1:0]  cdb1_tag,
    input  logic [DATA_WIDTH-1:0] cdb1_value,
    input  logic                  cdb2_valid,
    input  logic [TAG_WIDTH-1:0]  cdb2_tag,
    input  logic [DATA_WIDTH-1:0] cdb2_value,
    input  logic [TAG_WIDTH-1:0]  src1_tag,
    output logic                  src1_ready,
    output logic [DATA_WIDTH-1:0] src1_value,
    input  logic [TAG_WIDTH-1:0]  src2_tag,
    output logic                  src2_ready,
    output logic [DATA_WIDTH-1:0] src2_value,
    output logic                  commit_valid,
    output logic [TAG_WIDTH-1:0]  commit_tag,
    output logic                  commit_has_rd,
    output logic [REG_WIDTH-1:0]  commit_rd,
    output logic [DATA_WIDTH-1:0] commit_value,
    output logic [63:0]           commit_pc,
    output logic [TAG_WIDTH-1:0]  count
);

    localparam int IDX_W = $clog2(ROB_SIZE);

    // Control state (reset) kept apart from payload (no reset).
    logic [ROB_SIZE-1:0]   r_valid;
    logic [ROB_SIZE-1:0]   r_done;
    logic [TAG_WIDTH-1:0]  r_count;
    logic                  r_has_rd [ROB_SIZE];
    logic [REG_WIDTH-1:0]  r_rd     [ROB_SIZE];
    logic [63:0]           r_pc     [ROB_SIZE];
    logic [DATA_WIDTH-1:0] r_value  [ROB_SIZE];

    logic [IDX_W-1:0]    w_head;
    logic [IDX_W-1:0]    w_tail;
    logic                w_alloc;
    logic                w_commit;
    logic [ROB_SIZE-1:0] w_wb1;
    logic [ROB_SIZE-1:0] w_wb2;
    cdb_packet_t         w_cdb1;
    cdb_packet_t         w_cdb2;
    rob_entry_t          w_head_ent;

    assign w_cdb1 = '{valid: cdb1_valid, tag: cdb1_tag, value: cdb1_value};
    assign w_cdb2 = '{valid: cdb2_valid, tag: cdb2_tag, value: cdb2_value};

    // Readiness looks only at the registered count: a full buffer refuses
    // even when the head retires in the same cycle.
    assign alloc_ready = (r_count < TAG_WIDTH'(ROB_SIZE));
    assign alloc_tag   = rob_idx_to_tag(w_tail);
    assign w_alloc     = alloc_valid && alloc_ready && !flush;
    assign w_commit    = commit_valid;
    assign count       = r_count;

    rob_pointer #(.DEPTH(ROB_SIZE), .W(IDX_W)) u_head (
        .clk   (clk),
        .reset (reset),
        .i_clr (flush),
        .i_inc (w_commit),
        .o_ptr (w_head)
    );

    rob_pointer #(.DEPTH(ROB_SIZE), .W(IDX_W)) u_tail (
        .clk   (clk),
        .reset (reset),
        .i_clr (flush),
        .i_inc (w_alloc),
        .o_ptr (w_tail)
    );

    // Tag 0 and out-of-range tags never equal i+1, so they fall out here.
    // cdb2 is masked by cdb1 so a duplicate tag keeps the cdb1 value.
    always_comb begin
        w_wb1 = '0;
        w_wb2 = '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
            w_wb1[i] = w_cdb1.valid && (w_cdb1.tag == TAG_WIDTH'(i + 1)) && r_valid[i] && !r_done[i];
            w_wb2[i] = w_cdb2.valid && (w_cdb2.tag == TAG_WIDTH'(i + 1)) && r_valid[i] && !r_done[i]
                       && !w_wb1[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_done  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_done  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                if (w_wb1[i] || w_wb2[i]) begin
                    r_done[i] <= 1'b1;
                end
            end
            // Commit and allocate never target the same slot: that would
            // need a full buffer, which blocks allocation.
            if (w_commit) begin
                r_valid[w_head] <= 1'b0;
            end
            if (w_alloc) begin
                r_valid[w_tail] <= 1'b1;
                r_done[w_tail]  <= 1'b0;
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + TAG_WIDTH'(1);
                2'b01:   r_count <= r_count - TAG_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            if (w_wb1[i]) begin
                r_value[i] <= w_cdb1.value;
            end else if (w_wb2[i]) begin
                r_value[i] <= w_cdb2.value;
            end
        end
        if (w_alloc) begin
            r_has_rd[w_tail] <= alloc_has_rd;
            r_rd[w_tail]     <= alloc_rd;
            r_pc[w_tail]     <= alloc_pc;
            r_value[w_tail]  <= '0;
        end
    end

    // Head view; payload is masked while the head slot is empty so stale
    // data never leaves the buffer.
    always_comb begin
        w_head_ent        = '0;
        w_head_ent.valid  = r_valid[w_head];
        w_head_ent.done   = r_done[w_head];
        if (r_valid[w_head]) begin
            w_head_ent.has_rd = r_has_rd[w_head];
            w_head_ent.rd     = r_rd[w_head];
            w_head_ent.pc     = r_pc[w_head];
            w_head_ent.value  = r_value[w_head];
        end
    end

    assign commit_valid  = w_head_ent.valid && w_head_ent.done && !flush;
    assign commit_tag    = rob_idx_to_tag(w_head);
    assign commit_has_rd = w_head_ent.has_rd;
    assign commit_rd     = w_head_ent.rd;
    assign commit_pc     = w_head_ent.pc;
    assign commit_value  = w_head_ent.value;

    // {ready, value}; same-cycle broadcasts take precedence over the array.
    function automatic logic [DATA_WIDTH:0] lookup(input logic [TAG_WIDTH-1:0] tag);
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(tag - TAG_WIDTH'(1));
        if (tag == '0) begin
            lookup = {1'b1, {DATA_WIDTH{1'b0}}};
        end else if (w_cdb1.valid && (w_cdb1.tag == tag)) begin
            lookup = {1'b1, w_cdb1.value};
        end else if (w_cdb2.valid && (w_cdb2.tag == tag)) begin
            lookup = {1'b1, w_cdb2.value};
        end else if ((tag <= TAG_WIDTH'(ROB_SIZE)) && r_valid[idx] && r_done[idx]) begin
            lookup = {1'b1, r_value[idx]};
        end else begin
            lookup = '0;
        end
    endfunction

    assign {src1_ready, src1_value} = lookup(src1_tag);
    assign {src2_ready, src2_value} = lookup(src2_tag);

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a cycle model of the buffer plus a
// scoreboard of allocated instructions popped at every retirement.
module tb_reorder_buffer;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset, flush, alloc_valid, alloc_has_rd, alloc_ready;
    logic [4:0]  alloc_rd, alloc_tag;
    logic [63:0] alloc_pc;
    logic        cdb1_valid, cdb2_valid;
    logic [4:0]  cdb1_tag, cdb2_tag;
    logic [63:0] cdb1_value, cdb2_value;
    logic [4:0]  src1_tag, src2_tag;
    logic        src1_ready, src2_ready;
    logic [63:0] src1_value, src2_value;
    logic        commit_valid, commit_has_rd;
    logic [4:0]  commit_tag, commit_rd, count;
    logic [63:0] commit_value, commit_pc;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_has_rd(alloc_has_rd), .alloc_rd(alloc_rd),
        .alloc_pc(alloc_pc), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_value(cdb1_value),
        .cdb2_valid(cdb2_valid), .cdb2_tag(cdb2_tag), .cdb2_value(cdb2_value),
        .src1_tag(src1_tag), .src1_ready(src1_ready), .src1_value(src1_value),
        .src2_tag(src2_tag), .src2_ready(src2_ready), .src2_value(src2_value),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_has_rd(commit_has_rd),
        .commit_rd(commit_rd), .commit_value(commit_value), .commit_pc(commit_pc),
        .count(count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model
    bit          m_valid [N];
    bit          m_done  [N];
    logic [63:0] m_val   [N];
    int          m_head, m_tail, m_count;

    typedef struct {
        int          tag;
        logic        has_rd;
        logic [4:0]  rd;
        logic [63:0] pc;
    } sb_t;
    sb_t         sb[$];
    int          ctag_q[$];
    logic [63:0] cval_q[$];

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_done[i]  = 0;
        end
        m_head = 0; m_tail = 0; m_count = 0;
        sb.delete();
    endtask

    task automatic model_lookup(input logic [4:0] t, output logic r, output logic [63:0] v);
        r = 0; v = '0;
        if (t == 0) r = 1;
        else if (cdb1_valid && cdb1_tag == t) begin r = 1; v = cdb1_value; end
        else if (cdb2_valid && cdb2_tag == t) begin r = 1; v = cdb2_value; end
        else if (t <= N && m_valid[t-1] && m_done[t-1]) begin r = 1; v = m_val[t-1]; end
    endtask

    task automatic model_wb(input logic vld, input logic [4:0] t, input logic [63:0] v);
        if (vld && t >= 1 && t <= N && m_valid[t-1] && !m_done[t-1]) begin
            m_done[t-1] = 1;
            m_val[t-1]  = v;
        end
    endtask

    task automatic idle_inputs();
        flush = 0; alloc_valid = 0; alloc_has_rd = 0; alloc_rd = '0; alloc_pc = '0;
        cdb1_valid = 0; cdb1_tag = '0; cdb1_value = '0;
        cdb2_valid = 0; cdb2_tag = '0; cdb2_value = '0;
    endtask

    // One clock: compare at negedge, advance the model at posedge.
    task automatic step();
        logic        er;
        logic [63:0] ev;
        logic        ecv, acc;
        sb_t         e;
        @(negedge clk);
        ecv = !flush && m_valid[m_head] && m_done[m_head];
        acc = alloc_valid && (m_count < N);
        chk("commit_valid", 64'(commit_valid), 64'(ecv));
        chk("count", 64'(count), 64'(m_count));
        chk("alloc_ready", 64'(alloc_ready), 64'(m_count < N));
        chk("alloc_tag", 64'(alloc_tag), 64'(m_tail + 1));
        model_lookup(src1_tag, er, ev);
        chk("src1_ready", 64'(src1_ready), 64'(er));
        if (er) chk("src1_value", src1_value, ev);
        model_lookup(src2_tag, er, ev);
        chk("src2_ready", 64'(src2_ready), 64'(er));
        if (er) chk("src2_value", src2_value, ev);
        if (ecv && commit_valid) begin
            ctag_q.push_back(int'(commit_tag));
            cval_q.push_back(commit_value);
            if (sb.size() == 0) begin
                chk("sb_empty_on_commit", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("commit_tag", 64'(commit_tag), 64'(e.tag));
                chk("commit_has_rd", 64'(commit_has_rd), 64'(e.has_rd));
                if (e.has_rd) chk("commit_rd", 64'(commit_rd), 64'(e.rd));
                chk("commit_pc", commit_pc, e.pc);
                chk("commit_value", commit_value, m_val[m_head]);
            end
        end
        @(posedge clk);
        if (flush) begin
            model_clear();
        end else begin
            model_wb(cdb1_valid, cdb1_tag, cdb1_value);
            model_wb(cdb2_valid, cdb2_tag, cdb2_value);
            if (ecv) begin
                m_valid[m_head] = 0;
                m_head  = (m_head + 1) % N;
                m_count = m_count - 1;
            end
            if (acc) begin
                sb.push_back('{tag: m_tail + 1, has_rd: alloc_has_rd, rd: alloc_rd, pc: alloc_pc});
                m_valid[m_tail] = 1;
                m_done[m_tail]  = 0;
                m_val[m_tail]   = '0;
                m_tail  = (m_tail + 1) % N;
                m_count = m_count + 1;
            end
        end
        #1;
    endtask

    task automatic alloc1(input logic has_rd, input logic [4:0] rd, input logic [63:0] pc);
        alloc_valid = 1; alloc_has_rd = has_rd; alloc_rd = rd; alloc_pc = pc;
        step();
        alloc_valid = 0;
    endtask

    task automatic cdb(input int port, input logic [4:0] t, input logic [63:0] v);
        if (port == 1) begin cdb1_valid = 1; cdb1_tag = t; cdb1_value = v; end
        else begin cdb2_valid = 1; cdb2_tag = t; cdb2_value = v; end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1;
        repeat (cycles) @(posedge clk);
        #1;
        model_clear();
        reset = 0;
    endtask

    initial begin
        idle_inputs();
        src1_tag = '0; src2_tag = '0;
        reset = 1;
        model_clear();

        // Reset then idle
        do_reset(3);
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_alloc_ready", 64'(alloc_ready), 64'(1));
        chk("rst_alloc_tag", 64'(alloc_tag), 64'(1));
        chk("rst_commit_valid", 64'(commit_valid), 64'(0));
        step();

        // Out-of-order completion, in-order retire
        alloc1(1, 5'd1, 64'h100);
        alloc1(1, 5'd2, 64'h104);
        alloc1(1, 5'd3, 64'h108);
        ctag_q.delete(); cval_q.delete();
        src2_tag = 5'd2;
        cdb(1, 5'd3, 64'h33); step(); idle_inputs();
        cdb(2, 5'd1, 64'h11); step(); idle_inputs();
        cdb(1, 5'd2, 64'h22); step(); idle_inputs();
        step(); step(); step();
        chk("ooo_ncommits", 64'(ctag_q.size()), 64'(3));
        if (ctag_q.size() == 3) begin
            chk("ooo_tag0", 64'(ctag_q[0]), 64'(1));
            chk("ooo_tag1", 64'(ctag_q[1]), 64'(2));
            chk("ooo_tag2", 64'(ctag_q[2]), 64'(3));
            chk("ooo_val0", cval_q[0], 64'h11);
            chk("ooo_val1", cval_q[1], 64'h22);
            chk("ooo_val2", cval_q[2], 64'h33);
        end
        chk("ooo_count", 64'(count), 64'(0));

        // Reset mid-operation discards entries
        alloc1(1, 5'd7, 64'h200);
        alloc1(0, 5'd8, 64'h204);
        do_reset(2);
        chk("midrst_count", 64'(count), 64'(0));
        chk("midrst_alloc_tag", 64'(alloc_tag), 64'(1));
        step();

        // Full and wrap
        for (int i = 0; i < N; i++) alloc1(i[0], 5'(i + 1), 64'h1000 + 64'(i * 4));
        chk("full_count", 64'(count), 64'(16));
        chk("full_ready", 64'(alloc_ready), 64'(0));
        alloc1(1, 5'd9, 64'hDEAD);
        chk("full_ignored", 64'(count), 64'(16));
        cdb(1, 5'd1, 64'h5151); step(); idle_inputs();
        alloc1(1, 5'd9, 64'hBEEF);          // commit fires, allocation refused
        chk("full_commit_noalloc", 64'(count), 64'(15));
        chk("wrap_tag_offer", 64'(alloc_tag), 64'(1));
        alloc1(1, 5'd10, 64'h2000);
        chk("wrap_head", 64'(commit_tag), 64'(2));
        chk("wrap_count", 64'(count), 64'(16));

        // Same-cycle events
        src1_tag = 5'd4;
        cdb(1, 5'd4, 64'hAA); cdb(2, 5'd4, 64'hBB); step(); idle_inputs();
        chk("dup_src1_ready", 64'(src1_ready), 64'(1));
        chk("dup_src1_value", src1_value, 64'hAA);
        cdb(1, 5'd2, 64'h2); cdb(2, 5'd3, 64'h3); step(); idle_inputs();
        step();
        chk("pre_simul_count", 64'(count), 64'(15));
        alloc1(1, 5'd11, 64'h3000);
        chk("simul_count", 64'(count), 64'(15));
        step();

        // Lookup
        src2_tag = 5'd0; #1;
        chk("lk_tag0_ready", 64'(src2_ready), 64'(1));
        chk("lk_tag0_value", src2_value, 64'(0));
        src2_tag = 5'd5; #1;
        chk("lk_notdone_ready", 64'(src2_ready), 64'(0));
        step();

        // Flush mid-operation
        flush = 1; step(); flush = 0;
        src1_tag = 5'd2; src2_tag = 5'd3;
        for (int i = 0; i < 5; i++) alloc1(1, 5'(i + 20), 64'h4000 + 64'(i * 4));
        cdb(1, 5'd3, 64'h303); cdb(2, 5'd1, 64'h101); step(); idle_inputs();
        chk("fl_pre_count", 64'(count), 64'(5));
        flush = 1;
        cdb(2, 5'd2, 64'h202);
        #1;
        chk("fl_no_commit", 64'(commit_valid), 64'(0));
        step(); idle_inputs();
        chk("fl_count", 64'(count), 64'(0));
        chk("fl_alloc_tag", 64'(alloc_tag), 64'(1));
        alloc1(1, 5'd1, 64'h5000);
        alloc1(1, 5'd2, 64'h5004);
        chk("fl_cdb_dropped", 64'(src1_ready), 64'(0));

        // Drain
        cdb(1, 5'd1, 64'hF1); cdb(2, 5'd2, 64'hF2); step(); idle_inputs();
        step(); step(); step();
        chk("drain_count", 64'(count), 64'(0));
        chk("drain_sb", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
